// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle RV32I datapath: walks each instruction
// through fetch/decode/execute/memory/writeback and stalls on the memory ready handshake.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_pcUpdate;
    logic       w_branch;
    logic       w_irWrite;
    logic       w_memWrite;
    logic       w_regWrite;
    logic       w_done;
    logic       w_illegal;
    logic       w_adrSrc;
    logic [1:0] w_resultSrc;
    logic [1:0] w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic [1:0] w_aluOp;
    logic [1:0] w_immSrc;
    logic       w_validState;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // Unlisted outputs stay 0; unreachable encodings also clear every select.
    always_comb begin
        w_pcUpdate   = 1'b0;
        w_branch     = 1'b0;
        w_irWrite    = 1'b0;
        w_memWrite   = 1'b0;
        w_regWrite   = 1'b0;
        w_done       = 1'b0;
        w_illegal    = 1'b0;
        w_adrSrc     = 1'b0;
        w_resultSrc  = 2'b00;
        w_aluSrcA    = 2'b00;
        w_aluSrcB    = 2'b00;
        w_aluOp      = 2'b00;
        w_validState = 1'b1;
        case (r_state)
            S_FETCH: begin
                w_aluSrcB   = 2'b10;
                w_resultSrc = 2'b10;
                w_irWrite   = mem_ready;
                w_pcUpdate  = mem_ready;
            end
            S_DECODE: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b01;
                if (w_next == S_FETCH) begin
                    w_illegal = 1'b1;
                    w_done    = 1'b1;
                end
            end
            S_MEMADR: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
            end
            S_MEMREAD: begin
                w_adrSrc = 1'b1;
            end
            S_MEMWB: begin
                w_resultSrc = 2'b01;
                w_regWrite  = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrSrc   = 1'b1;
                w_memWrite = 1'b1;
                w_done     = mem_ready;
            end
            S_EXECUTER: begin
                w_aluSrcA = 2'b10;
                w_aluOp   = 2'b10;
            end
            S_EXECUTEI: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_aluOp   = 2'b10;
            end
            S_ALUWB: begin
                w_regWrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BEQ: begin
                w_aluSrcA = 2'b10;
                w_aluOp   = 2'b01;
                w_branch  = 1'b1;
                w_done    = 1'b1;
            end
            S_JAL: begin
                w_aluSrcA  = 2'b01;
                w_aluSrcB  = 2'b10;
                w_pcUpdate = 1'b1;
            end
            default: w_validState = 1'b0;
        endcase
    end

    always_comb begin
        w_immSrc = 2'b00;
        case (opcode)
            OP_SW:   w_immSrc = 2'b01;
            OP_BEQ:  w_immSrc = 2'b10;
            OP_JAL:  w_immSrc = 2'b11;
            default: w_immSrc = 2'b00;
        endcase
    end

    // Enables are gated by rst_n so nothing writes while reset is held.
    assign PCWrite    = rst_n & (w_pcUpdate | (w_branch & Zero));
    assign IRWrite    = rst_n & w_irWrite;
    assign MemWrite   = rst_n & w_memWrite;
    assign RegWrite   = rst_n & w_regWrite;
    assign instr_done = rst_n & w_done;
    assign illegal    = rst_n & w_illegal;
    assign AdrSrc     = w_adrSrc;
    assign ResultSrc  = w_resultSrc;
    assign ALUSrcA    = w_aluSrcA;
    assign ALUSrcB    = w_aluSrcB;
    assign ALUOp      = w_aluOp;
    assign ImmSrc     = w_validState ? w_immSrc : 2'b00;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: steps each instruction class cycle by
// cycle and compares state and write enables against hand-derived values.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    int assertCount = 0;
    int failCount   = 0;
    int doneCnt     = 0;
    int irwCnt      = 0;
    int memwCnt     = 0;
    int mark;
    int markIrw;
    int markMemw;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    // Enable vector order: {PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal}
    localparam logic [5:0] EN_NONE  = 6'b000000;
    localparam logic [5:0] EN_FETCH = 6'b110000;
    localparam logic [5:0] EN_WB    = 6'b000110;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_done) doneCnt = doneCnt + 1;
            if (IRWrite)    irwCnt  = irwCnt + 1;
            if (MemWrite)   memwCnt = memwCnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount = assertCount + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic z, input logic rdy);
        opcode    = op;
        Zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    // Checks the current cycle, then advances to just after the next rising edge.
    task automatic expectCycle(input string tag, input logic [3:0] expState, input logic [5:0] expEn);
        checkOutput({tag, ".state"}, 32'(state), 32'(expState));
        checkOutput({tag, ".en"}, 32'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal}), 32'(expEn));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(OP_LW, 1'b0, 1'b1);
        #10;
        checkOutput("rst.state", 32'(state), 32'd0);
        checkOutput("rst.en", 32'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal}), 32'(EN_NONE));
        checkOutput("rst.muxB", 32'(ALUSrcB), 32'd2);
        checkOutput("rst.result", 32'(ResultSrc), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Back-to-back lw, sw, add, addi
        mark = doneCnt;
        applyStimulus(OP_LW, 1'b0, 1'b1);
        expectCycle("lw.f", 4'd0, EN_FETCH);
        checkOutput("lw.imm", 32'(ImmSrc), 32'd0);
        expectCycle("lw.d", 4'd1, EN_NONE);
        expectCycle("lw.a", 4'd2, EN_NONE);
        checkOutput("lw.adr", 32'(AdrSrc), 32'd1);
        expectCycle("lw.r", 4'd3, EN_NONE);
        checkOutput("lw.res", 32'(ResultSrc), 32'd1);
        expectCycle("lw.wb", 4'd4, EN_WB);

        applyStimulus(OP_SW, 1'b0, 1'b1);
        expectCycle("sw.f", 4'd0, EN_FETCH);
        checkOutput("sw.imm", 32'(ImmSrc), 32'd1);
        expectCycle("sw.d", 4'd1, EN_NONE);
        expectCycle("sw.a", 4'd2, EN_NONE);
        expectCycle("sw.w", 4'd5, 6'b001010);

        applyStimulus(OP_R, 1'b0, 1'b1);
        expectCycle("add.f", 4'd0, EN_FETCH);
        expectCycle("add.d", 4'd1, EN_NONE);
        checkOutput("add.aluop", 32'(ALUOp), 32'd2);
        expectCycle("add.x", 4'd6, EN_NONE);
        expectCycle("add.wb", 4'd8, EN_WB);

        applyStimulus(OP_I, 1'b0, 1'b1);
        expectCycle("addi.f", 4'd0, EN_FETCH);
        expectCycle("addi.d", 4'd1, EN_NONE);
        checkOutput("addi.srcB", 32'(ALUSrcB), 32'd1);
        expectCycle("addi.x", 4'd7, EN_NONE);
        expectCycle("addi.wb", 4'd8, EN_WB);
        checkOutput("b2b.doneCount", 32'(doneCnt - mark), 32'd4);

        // beq taken and not taken
        applyStimulus(OP_BEQ, 1'b1, 1'b1);
        expectCycle("beq1.f", 4'd0, EN_FETCH);
        checkOutput("beq1.imm", 32'(ImmSrc), 32'd2);
        expectCycle("beq1.d", 4'd1, EN_NONE);
        checkOutput("beq1.aluop", 32'(ALUOp), 32'd1);
        expectCycle("beq1.b", 4'd9, 6'b100010);
        applyStimulus(OP_BEQ, 1'b0, 1'b1);
        expectCycle("beq0.f", 4'd0, EN_FETCH);
        expectCycle("beq0.d", 4'd1, EN_NONE);
        expectCycle("beq0.b", 4'd9, 6'b000010);

        // jal
        applyStimulus(OP_JAL, 1'b0, 1'b1);
        expectCycle("jal.f", 4'd0, EN_FETCH);
        checkOutput("jal.imm", 32'(ImmSrc), 32'd3);
        expectCycle("jal.d", 4'd1, EN_NONE);
        checkOutput("jal.srcA", 32'(ALUSrcA), 32'd1);
        checkOutput("jal.srcB", 32'(ALUSrcB), 32'd2);
        expectCycle("jal.j", 4'd10, 6'b100000);
        checkOutput("jal.res", 32'(ResultSrc), 32'd0);
        expectCycle("jal.wb", 4'd8, EN_WB);

        // lw with 3 FETCH stalls and 2 MEMREAD stalls: 10 cycles
        mark     = doneCnt;
        markIrw  = irwCnt;
        markMemw = memwCnt;
        applyStimulus(OP_LW, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) expectCycle("stall.f", 4'd0, EN_NONE);
        applyStimulus(OP_LW, 1'b0, 1'b1);
        expectCycle("stall.f1", 4'd0, EN_FETCH);
        applyStimulus(OP_LW, 1'b0, 1'b0);
        expectCycle("stall.d", 4'd1, EN_NONE);
        expectCycle("stall.a", 4'd2, EN_NONE);
        for (int i = 0; i < 2; i++) expectCycle("stall.r", 4'd3, EN_NONE);
        applyStimulus(OP_LW, 1'b0, 1'b1);
        expectCycle("stall.r1", 4'd3, EN_NONE);
        expectCycle("stall.wb", 4'd4, EN_WB);
        checkOutput("stall.next", 32'(state), 32'd0);
        checkOutput("stall.irw", 32'(irwCnt - markIrw), 32'd1);
        checkOutput("stall.memw", 32'(memwCnt - markMemw), 32'd0);
        checkOutput("stall.done", 32'(doneCnt - mark), 32'd1);

        // Illegal opcode
        applyStimulus(OP_BAD, 1'b1, 1'b1);
        expectCycle("ill.f", 4'd0, EN_FETCH);
        checkOutput("ill.dec", 32'(state), 32'd1);
        expectCycle("ill.d", 4'd1, 6'b000011);
        checkOutput("ill.back", 32'(state), 32'd0);

        // Reset asserted while MEMWRITE is stalled
        applyStimulus(OP_SW, 1'b0, 1'b1);
        expectCycle("rsw.f", 4'd0, EN_FETCH);
        expectCycle("rsw.d", 4'd1, EN_NONE);
        applyStimulus(OP_SW, 1'b0, 1'b0);
        expectCycle("rsw.a", 4'd2, EN_NONE);
        checkOutput("rsw.wstate", 32'(state), 32'd5);
        checkOutput("rsw.wen", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rsw.rstState", 32'(state), 32'd0);
        checkOutput("rsw.rstMemW", 32'(MemWrite), 32'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rsw.hold", 32'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal}), 32'(EN_NONE));
        rst_n = 1'b1;
        #1;
        expectCycle("rsw.f2", 4'd0, EN_FETCH);
        checkOutput("rsw.dec", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle RV32I datapath. It replaces single-cycle decode with a Moore FSM that walks each instruction through fetch, decode, execute, memory and writeback. It drives the shared ALU, the unified instruction/data memory port, the IR, the PC and the register file. It supports lw, sw, R-type, addi (I-type ALU), beq and jal, and it stalls on a memory ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from IR; stable from DECODE onward
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00=ALUOut, 01=MemData, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 (A)
- ALUSrcB  out  2  00=rs2 (B), 01=ImmExt, 10=constant 4
- ALUOp  out  2  00=add, 01=subtract (beq), 10=funct-decoded
- ImmSrc  out  2  combinational from opcode: lw/addi 00, sw 01, beq 10, jal 11, other 00
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state encoding, for debug

## Operation
- The state register resets asynchronously to FETCH. All outputs are decoded combinationally from the state, and from opcode, Zero and mem_ready where noted. Any output not listed for a state is 0.
- While rst_n=0, these outputs are forced to 0: PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal. The mux selects show FETCH values.
- Internal term PCUpdate. PCWrite = PCUpdate | (Branch & Zero).
- State outputs:
  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=mem_ready, PCUpdate=mem_ready.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target into ALUOut).
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD(3): ResultSrc=00, AdrSrc=1.
  - MEMWB(4): ResultSrc=01, RegWrite=1, instr_done=1.
  - MEMWRITE(5): ResultSrc=00, AdrSrc=1, MemWrite=1 (held until mem_ready), instr_done=mem_ready.
  - EXECUTER(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB(8): ResultSrc=00, RegWrite=1, instr_done=1.
  - BEQ(9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1.
  - JAL(10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Transitions:
  - FETCH: to DECODE if mem_ready, else stay.
  - DECODE:
    - 0000011 or 0100011 to MEMADR
    - 0110011 to EXECUTER
    - 0010011 to EXECUTEI
    - 1100011 to BEQ
    - 1101111 to JAL
    - any other opcode to FETCH with illegal=1 and instr_done=1; nothing is written.
  - MEMADR: 0000011 to MEMREAD, else to MEMWRITE.
  - MEMREAD: to MEMWB if mem_ready, else stay.
  - MEMWB to FETCH.
  - MEMWRITE: to FETCH if mem_ready, else stay.
  - EXECUTER and EXECUTEI to ALUWB.
  - JAL to ALUWB (rd = old PC+4).
  - ALUWB to FETCH.
  - BEQ to FETCH.
- Encodings 11–15 are unreachable. If reached, the next state is FETCH and all outputs are 0.

## Timing
- Cycles per instruction with mem_ready held at 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - jal 4
  - beq 3
  - illegal 2
- Each cycle that mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. During the stall, all outputs hold their values and no enable other than MemWrite is asserted.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.
- Zero is sampled only in BEQ, in the same cycle PCWrite is driven.
- instr_done asserts exactly once per instruction, on the cycle whose clock edge returns the FSM to FETCH.
- Reset mid-instruction: state goes to FETCH immediately and asynchronously. No partial write may occur after rst_n falls. The first FETCH begins on the first rising edge after rst_n rises.

## Test plan
- Reset: assert rst_n=0 mid-MEMWRITE. State=0 immediately and MemWrite=0. After release, FETCH with IRWrite=1 when mem_ready=1.
- Back-to-back lw, sw, add, addi with mem_ready=1. Check:
  - state sequence 0,1,2,3,4 / 0,1,2,5 / 0,1,6,8 / 0,1,7,8
  - RegWrite only in states 4 and 8
  - MemWrite only in state 5
  - instr_done counts 4
- beq with Zero=1: PCWrite=1 in BEQ. With Zero=0: PCWrite=0. Both take 3 cycles.
- jal: JAL drives PCWrite=1 with ALUSrcA=01, ALUSrcB=10. ALUWB then drives RegWrite=1 with ResultSrc=00.
- Stalls: mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEMREAD. lw takes 10 cycles. IRWrite pulses once. MemWrite stays 0 throughout.
- Opcode 0000000: DECODE pulses illegal=1 and instr_done=1, then returns to FETCH. No RegWrite, MemWrite or PCWrite is asserted outside FETCH.
